// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply (shift-add) / divide (restoring)
// engine. It iterates one bit per clock behind a start/finished handshake.
module muldiv_unit #(
    parameter int N = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    input  logic         start,
    output logic [N-1:0] result,
    output logic [N-1:0] high,
    output logic [3:0]   flags,
    output logic         finished
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic [N-1:0]  a_q, a_d;        // multiplicand, or dividend kept for div-by-zero
    logic [N-1:0]  b_q, b_d;        // divisor
    logic [N-1:0]  acc_q, acc_d;    // upper product word / partial remainder
    logic [N-1:0]  sh_q, sh_d;      // multiplier->low product, or dividend->quotient
    logic [N-1:0]  result_q, result_d;
    logic [N-1:0]  high_q, high_d;
    logic [3:0]    flags_q, flags_d;

    logic          op_ok;
    logic [N:0]    mul_sum;
    logic [N:0]    div_shift;
    logic          div_ge;
    logic [N-1:0]  fin_res, fin_high;
    logic          fin_zero;

    assign op_ok = (opcode == 4'd3) || (opcode == 4'd4);

    // State register
    always_ff @(posedge CLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && op_ok) state_d = RUN;
            RUN:  if (cnt_q == '0)    state_d = DONE;
            DONE: if (!start)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            result_q <= '0;
            high_q   <= '0;
            flags_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            high_q   <= high_d;
            flags_q  <= flags_d;
        end
    end

    // Operand latch, per-bit iteration and result/flag capture on entry to DONE
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        result_d = result_q;
        high_d   = high_q;
        flags_d  = flags_q;

        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
        // Remainder kept one bit wider during compare so divisors with MSB set work
        div_shift = {acc_q, sh_q[N-1]};
        div_ge    = div_shift >= {1'b0, b_q};

        if (is_div_q && (b_q == '0)) begin
            fin_res  = '1;
            fin_high = a_q;
        end else begin
            fin_res  = sh_q;
            fin_high = acc_q;
        end
        fin_zero = (fin_res == '0) && (is_div_q || (fin_high == '0));

        case (state_q)
            IDLE: begin
                if (start && op_ok) begin
                    is_div_d = (opcode == 4'd4);
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = CW'(N);
                    acc_d    = '0;
                    sh_d     = (opcode == 4'd4) ? a : b;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (is_div_q) begin
                        // Difference is below the divisor, so N bits suffice
                        acc_d = div_ge ? (div_shift[N-1:0] - b_q) : div_shift[N-1:0];
                        sh_d  = {sh_q[N-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[N:1];
                        sh_d  = {mul_sum[0], sh_q[N-1:1]};
                    end
                end else begin
                    result_d = fin_res;
                    high_d   = fin_high;
                    flags_d  = {~fin_res[N-1] & ~fin_zero,
                                is_div_q & (b_q == '0),
                                ~is_div_q & (fin_high != '0),
                                fin_zero};
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        finished = (state_q == DONE);
        result   = result_q;
        high     = high_q;
        flags    = flags_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (N = 16).
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] a, b;
    logic [3:0]  opcode;
    logic        start;
    logic [15:0] result, high;
    logic [3:0]  flags;
    logic        finished;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.N(16)) dut (
        .CLK(CLK), .reset(reset), .a(a), .b(b), .opcode(opcode),
        .start(start), .result(result), .high(high), .flags(flags),
        .finished(finished)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue an operation and count edges until finished; optionally drop start
    // or scramble inputs after a given edge. lat = edges after the sampling edge.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic [3:0] iop, input int drop_at,
                          input int perturb_at, output int lat);
        int n;
        a = ia; b = ib; opcode = iop; start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (n == drop_at)    start = 1'b0;
            if (n == perturb_at) begin
                a = 16'hBEEF; b = 16'h0003; opcode = 4'd3;
            end
        end while (!finished && n < 40);
        lat = n - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; opcode = '0;
        step(); step();
        total++;
        if (finished !== 1'b0 || result !== 16'h0 || high !== 16'h0 || flags !== 4'h0) begin
            bad++;
            $display("FAIL reset: fin=%b res=%h hi=%h fl=%b want 0/0000/0000/0000",
                     finished, result, high, flags);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_div_basic();
        int lat;
        run_op(16'd5, 16'd6, 4'd4, 0, 0, lat);
        total++;
        if (lat !== 17) begin bad++; $display("FAIL div5_6 latency: got %0d want 17", lat); end
        total++;
        if (result !== 16'h0000 || high !== 16'h0005 || flags !== 4'b0001) begin
            bad++;
            $display("FAIL div5_6: res=%h hi=%h fl=%b want 0000/0005/0001", result, high, flags);
        end
        start = 1'b0;
        step();
        total++;
        if (finished !== 1'b0 || result !== 16'h0000 || high !== 16'h0005) begin
            bad++;
            $display("FAIL div5_6 release: fin=%b res=%h hi=%h want 0/0000/0005", finished, result, high);
        end
    endtask

    task automatic test_mul();
        int lat;
        run_op(16'd300, 16'd400, 4'd3, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'hD4C0 || high !== 16'h0001 || flags !== 4'b0010) begin
            bad++;
            $display("FAIL mul300x400: lat=%0d res=%h hi=%h fl=%b want 17/D4C0/0001/0010",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
        run_op(16'hFFFF, 16'hFFFF, 4'd3, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'h0001 || high !== 16'hFFFE || flags !== 4'b1010) begin
            bad++;
            $display("FAIL mulFFFFxFFFF: lat=%0d res=%h hi=%h fl=%b want 17/0001/FFFE/1010",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
    endtask

    task automatic test_div_perturb();
        int lat;
        run_op(16'd1000, 16'd7, 4'd4, 0, 3, lat);
        total++;
        if (lat !== 17 || result !== 16'h008E || high !== 16'h0006 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL div1000_7: lat=%0d res=%h hi=%h fl=%b want 17/008E/0006/1000",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(16'd1234, 16'd0, 4'd4, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'hFFFF || high !== 16'h04D2 || flags !== 4'b0100) begin
            bad++;
            $display("FAIL div_by_zero: lat=%0d res=%h hi=%h fl=%b want 17/FFFF/04D2/0100",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
    endtask

    task automatic test_bad_opcode();
        int seen;
        seen = 0;
        a = 16'd9; b = 16'd9; opcode = 4'd1; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (finished) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL bad_opcode finished: got %0d cycles want 0", seen); end
        total++;
        if (result !== 16'hFFFF || high !== 16'h04D2 || flags !== 4'b0100) begin
            bad++;
            $display("FAIL bad_opcode hold: res=%h hi=%h fl=%b want FFFF/04D2/0100", result, high, flags);
        end
        start = 1'b0; step();
    endtask

    task automatic test_start_drop();
        int lat;
        run_op(16'd3, 16'd5, 4'd3, 5, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'h000F || high !== 16'h0000 || flags !== 4'b1000) begin
            bad++;
            $display("FAIL mul_drop: lat=%0d res=%h hi=%h fl=%b want 17/000F/0000/1000",
                     lat, result, high, flags);
        end
        step();
        total++;
        if (finished !== 1'b0) begin bad++; $display("FAIL mul_drop pulse: fin=%b want 0", finished); end
    endtask

    task automatic test_start_hold();
        int lat, held;
        run_op(16'd2, 16'd0, 4'd3, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'h0000 || high !== 16'h0000 || flags !== 4'b0001) begin
            bad++;
            $display("FAIL mul_zero: lat=%0d res=%h hi=%h fl=%b want 17/0000/0000/0001",
                     lat, result, high, flags);
        end
        held = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (finished) held++;
        end
        total++;
        if (held !== 3) begin bad++; $display("FAIL hold finished: got %0d cycles want 3", held); end
        start = 1'b0;
        step();
        total++;
        if (finished !== 1'b0) begin bad++; $display("FAIL hold release: fin=%b want 0", finished); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'd1000, 16'd7, 4'd4, 0, 0, lat);
        start = 1'b0;
        step();
        // New request presented right after the return to IDLE
        run_op(16'hFFFF, 16'h0100, 4'd4, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'h00FF || high !== 16'h00FF || flags !== 4'b1000) begin
            bad++;
            $display("FAIL back_to_back: lat=%0d res=%h hi=%h fl=%b want 17/00FF/00FF/1000",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a = 16'd1000; b = 16'd7; opcode = 4'd4; start = 1'b1;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        total++;
        if (finished !== 1'b0 || result !== 16'h0 || high !== 16'h0 || flags !== 4'h0) begin
            bad++;
            $display("FAIL reset_mid_run: fin=%b res=%h hi=%h fl=%b want 0/0000/0000/0000",
                     finished, result, high, flags);
        end
        reset = 1'b0; start = 1'b0;
        step();
        total++;
        if (finished !== 1'b0) begin bad++; $display("FAIL reset_mid_run idle: fin=%b want 0", finished); end
        run_op(16'd5, 16'd6, 4'd4, 0, 0, lat);
        total++;
        if (lat !== 17 || result !== 16'h0000 || high !== 16'h0005 || flags !== 4'b0001) begin
            bad++;
            $display("FAIL after_reset div5_6: lat=%0d res=%h hi=%h fl=%b want 17/0000/0005/0001",
                     lat, result, high, flags);
        end
        start = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_mul();
        test_div_perturb();
        test_div_zero();
        test_bad_opcode();
        test_start_drop();
        test_start_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
